instr_loader: RTL and testbench

- Writer side of the instruction-fetch path: receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Writes each word into InstructionRAM through its EDIT_SERIAL port, at word addresses 0..N-1, then writes the halt word 32'hFFFFFFFF at address N.
- Holds the CPU in reset until loading completes. Sits between the host/testbench byte source and InstructionRAM, alongside the CPU top.

---
 rtl/instr_loader_pkg.sv | 44 ++++
 rtl/instr_loader_byte_packer.sv | 38 +++
 rtl/instr_loader.sv | 146 ++++++++++++++
 tb/tb_instr_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction loader and its neighbours:
//   - loader FSM state encoding
//   - HALT_WORD, the word the CPU stop logic recognises as end of program
//   - width and field offsets of the InstructionRAM EDIT_SERIAL bus
//   - helpers to build an edit_serial write beat and classify states
// -----------------------------------------------------------------------------
package instr_loader_pkg;

   typedef enum logic [2:0] {
      LEN_HI,  // waiting for word count bits 15:8
      LEN_LO,  // waiting for word count bits 7:0
      WORD,    // collecting the 4 bytes of one program word
      WRITE,   // one-cycle write of the packed word
      TERM,    // one-cycle write of the halt word
      DONE,    // program resident, CPU released
      ERR      // header asked for more words than the RAM holds
   } state_t;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   // edit_serial = {wr_en, addr[31:0], data[31:0]}
   localparam int EDIT_W        = 65;
   localparam int EDIT_WR_BIT   = 64;
   localparam int EDIT_ADDR_LSB = 32;
   localparam int EDIT_DATA_LSB = 0;

   function automatic logic [EDIT_W-1:0] pack_edit(input logic [31:0] addr,
                                                   input logic [31:0] data);
      logic [EDIT_W-1:0] beat;
      beat                         = '0;
      beat[EDIT_WR_BIT]            = 1'b1;
      beat[EDIT_ADDR_LSB +: 32]    = addr;
      beat[EDIT_DATA_LSB +: 32]    = data;
      return beat;
   endfunction

   // States in which the loader takes bytes from the source.
   function automatic logic is_accept_state(input state_t s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == WORD);
   endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// loader_byte_packer
// Packs accepted bytes big-endian into a 32-bit word (first byte lands in
// bits 31:24) and flags the 4th byte of each word.
// Ports:
//   clk        system clock
//   clear      synchronous clear of byte counter and shift register
//   byte_en    a payload byte is being accepted this cycle
//   byte_data  the byte being accepted
//   word       shift register; holds the complete word after the 4th byte
//   word_ready high in the cycle the 4th byte is accepted
//   byte_cnt   number of bytes of the current word already accepted (0..3)
// -----------------------------------------------------------------------------
module loader_byte_packer (
   input  logic        clk,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_ready,
   output logic [1:0]  byte_cnt
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (clear) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (byte_en) begin
         byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
         word     <= {word[23:0], byte_data};
      end
   end

   assign word_ready = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Writer side of the instruction-fetch path. Receives a program as a byte
// stream (2-byte big-endian word count N, then N big-endian 32-bit words),
// writes the words to InstructionRAM addresses 0..N-1 over EDIT_SERIAL,
// then writes HALT_WORD at address N. The CPU is held in reset until the
// halt word is written.
// Ports:
//   CLK, RESET    clock; synchronous active-high reset
//   byte_valid    source presents byte_data
//   byte_data     program byte
//   byte_ready    registered; loader takes byte_data this cycle
//   reload        pulse; restarts loading from DONE or ERR
//   edit_serial   {wr_en, addr, data} to InstructionRAM
//   cpu_hold      CPU reset, high until the program is resident
//   done          program and halt word written
//   error         header word count exceeds RAM capacity
//   words_loaded  program words written so far (halt word excluded)
// -----------------------------------------------------------------------------
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int CNT_W = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              reload,
   output logic [EDIT_W-1:0] edit_serial,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  words_loaded
);

   // Largest N that still leaves room for the halt word at address N.
   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(DEPTH - 1);

   state_t           state, state_next;
   logic [7:0]       n_hi;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] header;
   logic [CNT_W-1:0] wl_inc;
   logic             xfer;
   logic             reload_take;
   logic             packer_clear;
   logic [31:0]      packed_word;
   logic             word_ready;
   logic [1:0]       byte_cnt;

   assign xfer   = byte_valid && byte_ready;
   assign header = CNT_W'({n_hi, byte_data});
   assign wl_inc = words_loaded + CNT_W'(1);

   // Clearing on reload as well as reset means a restarted stream never
   // inherits a partial word from the previous one.
   assign packer_clear = RESET || reload_take;

   loader_byte_packer u_packer (
      .clk        (CLK),
      .clear      (packer_clear),
      .byte_en    (xfer && (state == WORD)),
      .byte_data  (byte_data),
      .word       (packed_word),
      .word_ready (word_ready),
      .byte_cnt   (byte_cnt)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= LEN_HI;
         byte_ready   <= 1'b0;
         n_hi         <= '0;
         n_q          <= '0;
         words_loaded <= '0;
      end else begin
         state <= state_next;
         // Registered ready follows the state being entered, so it drops in
         // WRITE/TERM/DONE/ERR without a combinational path to the source.
         byte_ready <= is_accept_state(state_next);
         if (xfer && (state == LEN_HI)) n_hi <= byte_data;
         if (xfer && (state == LEN_LO)) n_q  <= header;
         if (state == WRITE)            words_loaded <= wl_inc;
         if (reload_take) begin
            n_hi         <= '0;
            n_q          <= '0;
            words_loaded <= '0;
         end
      end
   end

   // NOTE: every output of this block is given a default first so that no
   // path through the case statement can infer a latch.
   always_comb begin
      state_next  = state;
      reload_take = 1'b0;
      edit_serial = '0;
      cpu_hold    = 1'b1;
      done        = 1'b0;
      error       = 1'b0;

      case (state)
         LEN_HI: if (xfer) state_next = LEN_LO;
         LEN_LO: begin
            if (xfer) begin
               if (header > MAX_N)       state_next = ERR;
               else if (header == '0)    state_next = TERM;
               else                      state_next = WORD;
            end
         end
         WORD:   if (word_ready) state_next = WRITE;
         WRITE: begin
            // Address is the pre-increment count: word k lands at address k.
            edit_serial = pack_edit(32'(words_loaded), packed_word);
            state_next  = (wl_inc == n_q) ? TERM : WORD;
         end
         TERM: begin
            edit_serial = pack_edit(32'(n_q), HALT_WORD);
            state_next  = DONE;
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (reload) begin
               reload_take = 1'b1;
               state_next  = LEN_HI;
            end
         end
         ERR: begin
            error = 1'b1;
            if (reload) begin
               reload_take = 1'b1;
               state_next  = LEN_HI;
            end
         end
         default: state_next = LEN_HI;
      endcase
   end

   logic unused_ok;
   assign unused_ok = ^byte_cnt;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

   localparam int          DEPTH = 512;
   localparam int          CNT_W = 16;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic             CLK = 1'b0;
   logic             RESET = 1'b1;
   logic             byte_valid = 1'b0;
   logic [7:0]       byte_data = 8'h00;
   logic             reload = 1'b0;
   logic             byte_ready;
   logic [64:0]      edit_serial;
   logic             cpu_hold;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] words_loaded;

   int n_cmp = 0;
   int n_mis = 0;

   logic [64:0] obs[$];
   logic [64:0] exp_q[$];
   logic [7:0]  stim[$];

   always #5 CLK = ~CLK;

   instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .reload       (reload),
      .edit_serial  (edit_serial),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   // Record every RAM write beat, sampled mid-cycle.
   always @(negedge CLK) begin
      if (edit_serial[64] === 1'b1) obs.push_back(edit_serial);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required earlier", $time);
      $fatal(1);
   end

   function automatic logic [64:0] mk(input int addr, input logic [31:0] data);
      return {1'b1, 32'(addr), data};
   endfunction

   task automatic push_hdr(input logic [15:0] n);
      stim.push_back(n[15:8]);
      stim.push_back(n[7:0]);
   endtask

   task automatic push_word(input logic [31:0] w);
      stim.push_back(w[31:24]);
      stim.push_back(w[23:16]);
      stim.push_back(w[15:8]);
      stim.push_back(w[7:0]);
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send_byte(input logic [7:0] b, output int waits);
      waits      = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && waits < 50) begin
         @(negedge CLK);
         waits++;
      end
      if (waits >= 50) begin
         n_cmp++; n_mis++;
         $display("FAIL send_byte.timeout: byte_ready=%b required 1 within 50 cycles", byte_ready);
      end
      @(negedge CLK);
   endtask

   task automatic send_stream();
      int w;
      foreach (stim[i]) send_byte(stim[i], w);
      stim.delete();
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge CLK);
      n_cmp++;
      if (done !== 1'b1) begin
         n_mis++;
         $display("FAIL %s.done_timeout: done=%b required 1", name, done);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1; byte_valid = 1'b0; reload = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      obs.delete();
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      n_cmp++; if (byte_ready !== 1'b0)   begin n_mis++; $display("FAIL reset.byte_ready: got %b want 0", byte_ready); end
      n_cmp++; if (edit_serial !== 65'b0) begin n_mis++; $display("FAIL reset.edit_serial: got %h want 0", edit_serial); end
      n_cmp++; if (cpu_hold !== 1'b1)     begin n_mis++; $display("FAIL reset.cpu_hold: got %b want 1", cpu_hold); end
      n_cmp++; if (done !== 1'b0)         begin n_mis++; $display("FAIL reset.done: got %b want 0", done); end
      n_cmp++; if (error !== 1'b0)        begin n_mis++; $display("FAIL reset.error: got %b want 0", error); end
      n_cmp++; if (words_loaded !== '0)   begin n_mis++; $display("FAIL reset.words_loaded: got %0d want 0", words_loaded); end
      RESET = 1'b0;
      @(negedge CLK);
      n_cmp++; if (byte_ready !== 1'b1)   begin n_mis++; $display("FAIL reset.ready_after_release: got %b want 1", byte_ready); end
   endtask

   // byte_valid held high throughout: ready must dip exactly once per word.
   task automatic test_back_to_back();
      logic [7:0] s[10];
      int w;
      s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
      obs.delete();
      exp_q = '{mk(0, 32'h2008_0005), mk(1, 32'h0000_0000), mk(2, HALT)};
      for (int i = 0; i < 10; i++) begin
         send_byte(s[i], w);
         n_cmp++;
         if (w !== ((i == 6) ? 1 : 0)) begin
            n_mis++; $display("FAIL b2b.wait[%0d]: got %0d stall cycles want %0d", i, w, (i == 6) ? 1 : 0);
         end
         if (i == 1) begin
            n_cmp++; if (cpu_hold !== 1'b1) begin n_mis++; $display("FAIL b2b.cpu_hold_loading: got %b want 1", cpu_hold); end
         end
         if (i == 5 || i == 9) begin
            n_cmp++; if (byte_ready !== 1'b0) begin n_mis++; $display("FAIL b2b.ready_after_4th[%0d]: got %b want 0", i, byte_ready); end
         end
      end
      wait_done("b2b");
      byte_valid = 1'b0;
      n_cmp++; if (cpu_hold !== 1'b0)        begin n_mis++; $display("FAIL b2b.cpu_hold: got %b want 0", cpu_hold); end
      n_cmp++; if (words_loaded !== 16'd2)   begin n_mis++; $display("FAIL b2b.words_loaded: got %0d want 2", words_loaded); end
      n_cmp++; if (byte_ready !== 1'b0)      begin n_mis++; $display("FAIL b2b.ready_done: got %b want 0", byte_ready); end
      n_cmp++; if (obs.size() !== exp_q.size()) begin n_mis++; $display("FAIL b2b.write_count: got %0d want %0d", obs.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= obs.size() || obs[i] !== exp_q[i]) begin
            n_mis++; $display("FAIL b2b.write[%0d]: got %h want %h", i, (i < obs.size()) ? obs[i] : 65'h0, exp_q[i]);
         end
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      push_hdr(16'h0000);
      send_stream();
      n_cmp++; if (edit_serial !== mk(0, HALT)) begin n_mis++; $display("FAIL zero.halt_write: got %h want %h", edit_serial, mk(0, HALT)); end
      n_cmp++; if (done !== 1'b0)     begin n_mis++; $display("FAIL zero.done_early: got %b want 0", done); end
      n_cmp++; if (cpu_hold !== 1'b1) begin n_mis++; $display("FAIL zero.cpu_hold_term: got %b want 1", cpu_hold); end
      @(negedge CLK);
      n_cmp++; if (done !== 1'b1)     begin n_mis++; $display("FAIL zero.done: got %b want 1", done); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_mis++; $display("FAIL zero.cpu_hold: got %b want 0", cpu_hold); end
      n_cmp++; if (edit_serial !== 65'b0) begin n_mis++; $display("FAIL zero.edit_idle: got %h want 0", edit_serial); end
      n_cmp++; if (obs.size() !== 1)  begin n_mis++; $display("FAIL zero.write_count: got %0d want 1", obs.size()); end
   endtask

   // N = DEPTH is one too many: error, no writes, bytes refused; reload clears.
   task automatic test_overflow();
      int ready_seen;
      do_reset();
      push_hdr(16'h0200);
      send_stream();
      n_cmp++; if (error !== 1'b1)      begin n_mis++; $display("FAIL ovf.error: got %b want 1", error); end
      n_cmp++; if (cpu_hold !== 1'b1)   begin n_mis++; $display("FAIL ovf.cpu_hold: got %b want 1", cpu_hold); end
      n_cmp++; if (done !== 1'b0)       begin n_mis++; $display("FAIL ovf.done: got %b want 0", done); end
      ready_seen = 0;
      byte_valid = 1'b1; byte_data = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         if (byte_ready !== 1'b0) ready_seen++;
         @(negedge CLK);
      end
      byte_valid = 1'b0;
      n_cmp++; if (ready_seen !== 0)    begin n_mis++; $display("FAIL ovf.byte_ready: got %0d ready cycles want 0", ready_seen); end
      n_cmp++; if (obs.size() !== 0)    begin n_mis++; $display("FAIL ovf.writes: got %0d writes want 0", obs.size()); end
      reload = 1'b1;
      @(negedge CLK);
      reload = 1'b0;
      n_cmp++; if (error !== 1'b0)      begin n_mis++; $display("FAIL ovf.reload_error: got %b want 0", error); end
      n_cmp++; if (byte_ready !== 1'b1) begin n_mis++; $display("FAIL ovf.reload_ready: got %b want 1", byte_ready); end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      push_hdr(16'h0002);
      for (int i = 1; i <= 5; i++) stim.push_back(8'(i));
      send_stream();
      do_reset();
      push_hdr(16'h0001);
      push_word(32'hAABB_CCDD);
      send_stream();
      wait_done("midrst");
      exp_q = '{mk(0, 32'hAABB_CCDD), mk(1, HALT)};
      n_cmp++; if (words_loaded !== 16'd1) begin n_mis++; $display("FAIL midrst.words_loaded: got %0d want 1", words_loaded); end
      n_cmp++; if (obs.size() !== exp_q.size()) begin n_mis++; $display("FAIL midrst.write_count: got %0d want %0d", obs.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= obs.size() || obs[i] !== exp_q[i]) begin
            n_mis++; $display("FAIL midrst.write[%0d]: got %h want %h", i, (i < obs.size()) ? obs[i] : 65'h0, exp_q[i]);
         end
      end
   endtask

   // Starts in DONE. A reload pulse mid-load must be ignored.
   task automatic test_reload();
      obs.delete();
      reload = 1'b1;
      @(negedge CLK);
      reload = 1'b0;
      n_cmp++; if (done !== 1'b0)         begin n_mis++; $display("FAIL reload.done: got %b want 0", done); end
      n_cmp++; if (cpu_hold !== 1'b1)     begin n_mis++; $display("FAIL reload.cpu_hold: got %b want 1", cpu_hold); end
      n_cmp++; if (words_loaded !== '0)   begin n_mis++; $display("FAIL reload.words_loaded: got %0d want 0", words_loaded); end
      push_hdr(16'h0001);
      stim.push_back(8'h11);
      stim.push_back(8'h22);
      send_stream();
      reload = 1'b1;
      @(negedge CLK);
      reload = 1'b0;
      n_cmp++; if (cpu_hold !== 1'b1)     begin n_mis++; $display("FAIL reload.hold_midload: got %b want 1", cpu_hold); end
      stim.push_back(8'h33);
      stim.push_back(8'h44);
      send_stream();
      wait_done("reload");
      exp_q = '{mk(0, 32'h1122_3344), mk(1, HALT)};
      n_cmp++; if (cpu_hold !== 1'b0)     begin n_mis++; $display("FAIL reload.cpu_hold_end: got %b want 0", cpu_hold); end
      n_cmp++; if (obs.size() !== exp_q.size()) begin n_mis++; $display("FAIL reload.write_count: got %0d want %0d", obs.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= obs.size() || obs[i] !== exp_q[i]) begin
            n_mis++; $display("FAIL reload.write[%0d]: got %h want %h", i, (i < obs.size()) ? obs[i] : 65'h0, exp_q[i]);
         end
      end
   endtask

   // N = DEPTH-1: the halt word lands on the last RAM address.
   task automatic test_max_depth();
      logic [31:0] w;
      do_reset();
      exp_q.delete();
      push_hdr(16'(DEPTH - 1));
      for (int i = 0; i < DEPTH - 1; i++) begin
         w = {16'(i), ~16'(i)};
         push_word(w);
         exp_q.push_back(mk(i, w));
      end
      exp_q.push_back(mk(DEPTH - 1, HALT));
      send_stream();
      wait_done("maxd");
      n_cmp++; if (error !== 1'b0)   begin n_mis++; $display("FAIL maxd.error: got %b want 0", error); end
      n_cmp++; if (words_loaded !== 16'(DEPTH - 1)) begin n_mis++; $display("FAIL maxd.words_loaded: got %0d want %0d", words_loaded, DEPTH - 1); end
      n_cmp++; if (obs.size() !== exp_q.size()) begin n_mis++; $display("FAIL maxd.write_count: got %0d want %0d", obs.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= obs.size() || obs[i] !== exp_q[i]) begin
            n_mis++; $display("FAIL maxd.write[%0d]: got %h want %h", i, (i < obs.size()) ? obs[i] : 65'h0, exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_zero_len();
      test_overflow();
      test_reset_mid_load();
      test_reload();
      test_max_depth();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
